imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM. Receives a program image as a
//  byte stream (valid/ready), assembles big-endian 32-bit words and drives the
//  instruction memory write port. Holds the CPU in reset while loading, and
//  releases it only after the image checksum passes (FuSa load integrity).
// PARAMETERS
//  ADDR_W  8    word-address width of the instruction memory
//  WORDS   256  memory depth in words; the max loadable image is WORDS words
// PORTS
//  clk       in   1       clock; all state updates on the rising edge
//  rst_n     in   1       asynchronous active-low reset
//  start     in   1       1-cycle pulse: begin a load, or abort and restart one
//  in_valid  in   1       stream byte valid
//  in_data   in   8       stream byte
//  in_ready  out  1       loader accepts a byte; transfer = in_valid & in_ready
//  we        out  1       imem write enable, 1-cycle pulse per word
//  waddr     out  ADDR_W  imem word address
//  wdata     out  32      imem write data
//  cpu_hold  out  1       holds the CPU in reset while high
//  busy      out  1       load in progress (LEN_HI..CSUM)
//  done      out  1       1-cycle pulse: image loaded and checksum OK
//  err       out  1       sticky; length or checksum failure
// BEHAVIOUR
//  Reset values: all outputs 0, waddr=0, wdata=0, state IDLE.
//  Frame: LEN_HI, LEN_LO (N, 16-bit, big-endian), then N*4 payload bytes
//   (MSB first per word), then 1 checksum byte = XOR of all payload bytes.
//   Length bytes are not included in the checksum.
//  States:
//   IDLE   : in_ready=0. start -> LEN_HI; set cpu_hold=1, busy=1, err=0;
//            clear the word index, byte count and XOR accumulator.
//   LEN_HI : in_ready=1; on transfer, latch N[15:8] -> LEN_LO.
//   LEN_LO : in_ready=1; on transfer, latch N[7:0]. Then:
//            N>WORDS -> ERR; N==0 -> CSUM; otherwise -> DATA.
//   DATA   : in_ready=1. Shift each byte into the word and XOR it into the
//            accumulator. On the 4th byte of a word, the next cycle gives we=1,
//            waddr=word index, wdata=assembled word; the index then increments.
//            When the Nth word's 4th byte is accepted -> CSUM.
//   CSUM   : in_ready=1. On transfer: byte==acc -> DONE, else -> ERR.
//   DONE   : one cycle. done=1, and cpu_hold=0 and busy=0 in this same cycle;
//            then IDLE.
//   ERR    : err=1 (sticky), busy=0, in_ready=0, cpu_hold stays 1. Exit only
//            on start or reset.
//  Gaps in in_valid stall the FSM with no state change. Byte acceptance is
//   independent of the we pulse; a new byte may be accepted in the same cycle
//   as we.
//  start while busy or in ERR: abort, then restart at LEN_HI (cleared as for
//   IDLE). Words already written are not rolled back. No we is issued for a
//   partial word.
//  start in the same cycle as a transfer: start wins; the byte is dropped,
//   and in_ready is low in that cycle.
//  The word index never wraps; N<=WORDS guarantees a maximum of WORDS-1.
//  rst_n low at any time, mid-load included: immediate return to the reset
//   values; cpu_hold=0.
//  A loaded image persists in memory; the loader never reads the memory.
// TESTING
//  1 start; stream 00 03 | 20 01 00 05 20 02 00 0a 00 22 18 20 | 16 -> we at
//    addr 0,1,2 with 0x20010005, 0x2002000a, 0x00221820; done pulse; cpu_hold=0.
//  2 Same frame with checksum 17 -> three we pulses, then err=1, done never
//    pulses, cpu_hold stays 1, in_ready=0.
//  3 Length 01 01 (N=257 > 256) -> ERR right after LEN_LO; no we; err=1.
//  4 Length 00 00, checksum 00 -> done, no we; checksum 01 -> err.
//  5 Test 1 with random in_valid gaps -> identical we/addr/data sequence and
//    done.
//  6 Drop rst_n after 5 payload bytes -> all outputs 0 at once; a new start
//    plus the full frame gives the result of test 1. start after 5 bytes ->
//    reloads cleanly; the first word is written exactly once.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Loads a program image into the instruction memory from a byte stream.
//   Frame format: LEN_HI, LEN_LO (word count N, big-endian), N*4 payload bytes
//   (each word MSB first), then one checksum byte equal to the XOR of all
//   payload bytes. The CPU is held in reset from start until the checksum has
//   been verified.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     1-cycle pulse: begin a load (aborts and restarts a running one)
//   in_valid  stream byte valid
//   in_data   stream byte
//   in_ready  loader accepts a byte (transfer = in_valid & in_ready)
//   we        imem write enable, one pulse per assembled word
//   waddr     imem word address
//   wdata     imem write data
//   cpu_hold  CPU held in reset while high
//   busy      load in progress
//   done      1-cycle pulse: image loaded and checksum correct
//   err       sticky length/checksum failure, cleared by the next start
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int WORDS  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state;
  logic [7:0]          len_hi;
  logic [15:0]         len;
  logic [23:0]         word_sr;   // first three bytes of the word in flight
  logic [1:0]          byte_cnt;  // bytes already collected for this word
  logic [ADDR_W-1:0]   word_idx;
  logic [7:0]          acc;       // running XOR of payload bytes

  logic                accepting;
  logic                xfer;
  logic [15:0]         len_full;
  logic                last_word;

  assign accepting = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA)   || (state == S_CSUM);
  // A start pulse takes priority over any byte offered in the same cycle,
  // so the stream must see in_ready low then.
  assign in_ready  = accepting & ~start;
  assign xfer      = in_valid & in_ready;
  assign len_full  = {len_hi, in_data};
  // The index is only advanced for non-final words, so it never wraps.
  assign last_word = ((17'(word_idx) + 17'd1) == {1'b0, len});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      len_hi   <= '0;
      len      <= '0;
      word_sr  <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      acc      <= '0;
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      cpu_hold <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (start) begin
        // Abort or begin: already written words are left in memory, and a
        // partially assembled word is simply discarded.
        state    <= S_LEN_HI;
        cpu_hold <= 1'b1;
        busy     <= 1'b1;
        err      <= 1'b0;
        word_idx <= '0;
        byte_cnt <= '0;
        acc      <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_LEN_HI: begin
            if (xfer) begin
              len_hi <= in_data;
              state  <= S_LEN_LO;
            end
          end
          S_LEN_LO: begin
            if (xfer) begin
              len <= len_full;
              if (17'(len_full) > 17'(WORDS)) begin
                state <= S_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
              end else if (len_full == 16'd0) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (xfer) begin
              acc      <= acc ^ in_data;
              word_sr  <= {word_sr[15:0], in_data};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                we    <= 1'b1;
                waddr <= word_idx;
                wdata <= {word_sr, in_data};
                if (last_word) begin
                  state <= S_CSUM;
                end else begin
                  word_idx <= word_idx + 1'b1;
                end
              end
            end
          end
          S_CSUM: begin
            if (xfer) begin
              busy <= 1'b0;
              if (in_data == acc) begin
                state    <= S_DONE;
                done     <= 1'b1;
                cpu_hold <= 1'b0;
              end else begin
                state <= S_ERR;
                err   <= 1'b1;
              end
            end
          end
          S_DONE:  state <= S_IDLE;
          S_ERR:   ;  // wait for start or reset; cpu_hold stays asserted
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int WORDS  = 256;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  imem_loader #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The load is described by the list of bytes accepted since the last start;
  // every expected event follows from that list's length and contents.
  localparam int M_IDLE = 0, M_LOAD = 1, M_ERR = 2, M_DONE = 3;
  int          m_mode  = M_IDLE;
  int          m_n     = 0;
  logic [7:0]  mq[$];
  logic        e_we = 0, e_done = 0, e_err = 0, e_hold = 0, e_busy = 0;
  logic [7:0]  e_waddr = 0;
  logic [31:0] e_wdata = 0;

  task automatic model_accept(input logic [7:0] b);
    int c;
    logic [7:0] x;
    mq.push_back(b);
    c = mq.size();
    if (c == 2) begin
      m_n = int'({mq[0], mq[1]});
      if (m_n > WORDS) begin
        m_mode = M_ERR; e_err = 1; e_busy = 0;
      end
    end else if (c > 2 && c <= 2 + 4 * m_n) begin
      if ((c - 2) % 4 == 0) begin
        e_we    = 1;
        e_waddr = 8'((c - 2) / 4 - 1);
        e_wdata = {mq[c-4], mq[c-3], mq[c-2], mq[c-1]};
      end
    end else if (c == 3 + 4 * m_n) begin
      x = 8'h00;
      for (int i = 2; i < c - 1; i++) x ^= mq[i];
      e_busy = 0;
      if (x == b) begin
        m_mode = M_DONE; e_done = 1; e_hold = 0;
      end else begin
        m_mode = M_ERR; e_err = 1;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = M_IDLE; mq.delete(); m_n = 0;
      e_we = 0; e_waddr = 0; e_wdata = 0; e_done = 0; e_err = 0; e_hold = 0; e_busy = 0;
    end else begin
      e_we = 0; e_done = 0;
      if (start) begin
        m_mode = M_LOAD; mq.delete(); m_n = 0;
        e_err = 0; e_hold = 1; e_busy = 1;
      end else if (m_mode == M_LOAD && in_valid) begin
        model_accept(in_data);
      end else if (m_mode == M_DONE) begin
        m_mode = M_IDLE;
      end
    end
  end

  // ---------------- compare + write log ----------------
  logic [39:0] wlog[$];
  int          done_cnt = 0;

  always @(negedge clk) begin
    chk("in_ready", in_ready, (m_mode == M_LOAD) && !start);
    chk("we", we, e_we);
    chk("done", done, e_done);
    chk("err", err, e_err);
    chk("cpu_hold", cpu_hold, e_hold);
    chk("busy", busy, e_busy);
    if (e_we) begin
      chk("waddr", waddr, e_waddr);
      chk("wdata", wdata, e_wdata);
    end
    if (we) wlog.push_back({waddr, wdata});
    if (done) done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic with_byte);
    start = 1; in_valid = with_byte; in_data = 8'($urandom);
    tick();
    start = 0; in_valid = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic gaps);
    logic acc;
    int budget;
    acc = 0; budget = 0;
    while (!acc) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      #3 acc = in_valid && in_ready;
      @(posedge clk); #1;
      budget++;
      if (budget > 200 && !acc) begin
        chk("stall_timeout", 1, 0);
        break;
      end
    end
    in_valid = 0;
  endtask

  task automatic send_bytes(input logic [7:0] f[$], input int cnt, input logic gaps);
    for (int i = 0; i < cnt && i < f.size(); i++) send_byte(f[i], gaps);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_test1_log(input string tag);
    chk({tag, "_nwr"}, wlog.size(), 3);
    chk({tag, "_w0"}, wlog[0], {8'd0, 32'h20010005});
    chk({tag, "_w1"}, wlog[1], {8'd1, 32'h2002000a});
    chk({tag, "_w2"}, wlog[2], {8'd2, 32'h00221820});
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_hold"}, cpu_hold, 0);
  endtask

  logic [7:0] f1[$] = '{8'h00, 8'h03,
                        8'h20, 8'h01, 8'h00, 8'h05, 8'h20, 8'h02, 8'h00, 8'h0a,
                        8'h00, 8'h22, 8'h18, 8'h20, 8'h16};
  logic [7:0] f2[$];
  logic [7:0] fr[$];

  initial begin
    rst_n = 0; start = 0; in_valid = 0; in_data = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    tick();
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_hold", cpu_hold, 0);

    // 1: reference frame
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_bytes(f1, f1.size(), 0); idle(3);
    check_test1_log("t1");

    // 2: bad checksum
    f2 = f1; f2[14] = 8'h17;
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_bytes(f2, f2.size(), 0); idle(3);
    chk("t2_nwr", wlog.size(), 3);
    chk("t2_err", err, 1);
    chk("t2_done", done_cnt, 0);
    chk("t2_hold", cpu_hold, 1);
    chk("t2_ready", in_ready, 0);

    // 3: length 257
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_byte(8'h01, 0); send_byte(8'h01, 0); idle(3);
    chk("t3_nwr", wlog.size(), 0);
    chk("t3_err", err, 1);
    chk("t3_busy", busy, 0);

    // 4: empty image, good and bad checksum
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); idle(3);
    chk("t4a_done", done_cnt, 1);
    chk("t4a_nwr", wlog.size(), 0);
    chk("t4a_err", err, 0);
    pulse_start(0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h01, 0); idle(3);
    chk("t4b_err", err, 1);
    chk("t4b_done", done_cnt, 1);

    // 5: reference frame with valid gaps
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_bytes(f1, f1.size(), 1); idle(3);
    check_test1_log("t5");

    // 6a: asynchronous reset mid-load, then a full reload
    pulse_start(0); send_bytes(f1, 7, 0);
    rst_n = 0;
    #2;
    chk("t6_rst_out", {in_ready, we, waddr, wdata, cpu_hold, busy, done, err}, 0);
    tick(); rst_n = 1; tick();
    wlog.delete(); done_cnt = 0;
    pulse_start(0); send_bytes(f1, f1.size(), 0); idle(3);
    check_test1_log("t6a");

    // 6b: restart after 5 payload bytes, with a byte offered alongside start
    pulse_start(0); send_bytes(f1, 7, 0); idle(2);
    wlog.delete(); done_cnt = 0;
    pulse_start(1); send_bytes(f1, f1.size(), 0); idle(3);
    check_test1_log("t6b");

    // randomized frames: lengths, data, checksums, gaps and aborts
    for (int it = 0; it < 40; it++) begin
      int n;
      logic [7:0] x;
      logic gaps;
      int r;
      r = $urandom_range(0, 19);
      if (it == 7) n = WORDS;
      else if (r == 0) n = $urandom_range(WORDS + 1, WORDS + 40);
      else n = $urandom_range(0, 6);
      fr.delete();
      fr.push_back(8'(n >> 8)); fr.push_back(8'(n));
      x = 8'h00;
      if (n <= WORDS) begin
        for (int i = 0; i < 4 * n; i++) begin
          logic [7:0] b;
          b = 8'($urandom);
          x ^= b;
          fr.push_back(b);
        end
        fr.push_back(($urandom_range(0, 4) == 0) ? x ^ 8'(1 + $urandom_range(0, 254)) : x);
      end
      gaps = 1'($urandom_range(0, 1));
      pulse_start(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) send_bytes(fr, $urandom_range(0, fr.size() - 1), gaps);
      else send_bytes(fr, fr.size(), gaps);
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
